// File: rtl/adder_tree_seq_ctrl.sv
// Sequencer/accumulator around a free-running adder tree: tags windows, sums N passes, buffers results.
// Latency: window accept to res_valid_o is LATENCY+1 cycles for single-pass results.
// Backpressure: credit-based; last-of-result windows stall unless FIFO + in-flight results < DEPTH.
module adder_tree_seq_ctrl #(
    parameter int W       = 64,
    parameter int LATENCY = 6,
    parameter int DEPTH   = 8,
    parameter int PASS_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [PASS_W-1:0] cfg_passes_i,
    input  logic              win_valid_i,
    output logic              win_ready_o,
    input  logic [W-1:0]      tree_sum_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [W-1:0]      res_data_o,
    output logic              busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + LATENCY + 1);

    typedef struct packed {
        logic first;
        logic last;
        logic vld;
    } tag_t;

    tag_t              pipe_q [LATENCY];
    tag_t              exit_tag;
    logic [PASS_W-1:0] in_cnt_q;
    logic [PASS_W-1:0] passes_q;
    logic [PASS_W-1:0] passes_eff;
    logic              first_next;
    logic              last_next;
    logic              accept;
    logic [W-1:0]      acc_q;
    logic [W-1:0]      acc_next;
    logic [W-1:0]      mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic [CNT_W-1:0]  lq;
    logic              pipe_any;
    logic              push;
    logic              pop;

    // The cfg value is only consulted at the first pass; later passes use the latched count.
    always_comb begin
        first_next = (in_cnt_q == '0);
        passes_eff = passes_q;
        if (first_next) begin
            passes_eff = (cfg_passes_i == '0) ? PASS_W'(1) : cfg_passes_i;
        end
        last_next = (in_cnt_q == passes_eff - PASS_W'(1));
    end

    // Every last-tagged entry in the pipe holds a future FIFO slot.
    always_comb begin
        lq       = '0;
        pipe_any = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            lq       = lq + CNT_W'(pipe_q[i].last);
            pipe_any = pipe_any | pipe_q[i].vld;
        end
    end

    assign win_ready_o = !last_next || ((fifo_cnt_q + lq) < CNT_W'(DEPTH));
    assign accept      = win_valid_i & win_ready_o;
    assign exit_tag    = pipe_q[LATENCY-1];
    assign acc_next    = exit_tag.first ? tree_sum_i : (acc_q + tree_sum_i);
    assign push        = exit_tag.vld & exit_tag.last;
    assign res_valid_o = (fifo_cnt_q != '0);
    assign res_data_o  = mem_q[rd_ptr_q];
    assign pop         = res_valid_o & res_ready_i;
    assign busy_o      = pipe_any | (in_cnt_q != '0) | (fifo_cnt_q != '0);

    // The tag pipe mirrors the tree's stages so its exit lines up with tree_sum_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0].vld   <= accept;
            pipe_q[0].first <= accept & first_next;
            pipe_q[0].last  <= accept & last_next;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_cnt_q <= '0;
            passes_q <= '0;
        end else if (accept) begin
            if (first_next) begin
                passes_q <= passes_eff;
            end
            in_cnt_q <= last_next ? '0 : (in_cnt_q + PASS_W'(1));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (exit_tag.vld) begin
            acc_q <= acc_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                assert (fifo_cnt_q < CNT_W'(DEPTH));
                mem_q[wr_ptr_q] <= acc_next;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : (wr_ptr_q + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : (rd_ptr_q + PTR_W'(1));
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_tree_seq_ctrl.sv
// Bench for adder_tree_seq_ctrl: models a 6-stage tree, queues hand-computed results, monitor compares pops.
module tb_adder_tree_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg;
    logic        win_valid;
    logic        win_ready;
    logic [63:0] win_sum;
    logic [63:0] tree_sum;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] d;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [63:0] tree_pipe [6];
    logic        tb_acc;

    adder_tree_seq_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cfg_passes_i (cfg),
        .win_valid_i  (win_valid),
        .win_ready_o  (win_ready),
        .tree_sum_i   (tree_sum),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tree model never resets, so stale sums stay visible after a DUT reset.
    always @(negedge clk) tb_acc = win_valid && win_ready;
    always @(posedge clk) begin
        tree_pipe[0] <= tb_acc ? win_sum : (64'hBAD0_0000_0000_0000 | 64'(cyc));
        for (int k = 1; k < 6; k++) tree_pipe[k] <= tree_pipe[k-1];
    end
    assign tree_sum = tree_pipe[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] d, input int c);
        exp_t e;
        e.d   = d;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", res_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res_data", res_data, e.d);
                if (e.cyc >= 0) chk("res_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic send(input logic [63:0] s, output int acc_cyc);
        int t;
        t = 0;
        win_valid = 1'b1;
        win_sum   = s;
        while (!win_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!win_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got win_ready 0 expected 1");
        end
        acc_cyc = cyc;
        @(posedge clk); #1;
        win_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (exp_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL %s: got pending %0d busy %0b expected 0 0", name, exp_q.size(), busy);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        int spurious;
        rst_n     = 1'b0;
        cfg       = 8'd1;
        win_valid = 1'b0;
        win_sum   = '0;
        res_ready = 1'b0;
        idle(3);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_win_ready", 64'(win_ready), 1);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_res_data", res_data, 0);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_win_ready", 64'(win_ready), 1);

        // Single-pass, back-to-back, with exact output cycle
        res_ready = 1'b1;
        cfg       = 8'd1;
        send(64'd10, c); push_exp(64'd10, c + 7);
        send(64'd20, c); push_exp(64'd20, c + 7);
        send(64'd30, c); push_exp(64'd30, c + 7);
        drain("drain_single");

        // Three passes per result
        cfg = 8'd3;
        push_exp(64'd6, -1);
        push_exp(64'd15, -1);
        for (int i = 1; i <= 6; i++) send(64'(i), c);
        chk("busy_inflight", 64'(busy), 1);
        drain("busy_after_last_pop");

        // Credit backpressure with consumer stalled
        cfg       = 8'd1;
        res_ready = 1'b0;
        win_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            win_sum = 64'(100 + n);
            if (win_ready) begin
                push_exp(64'(100 + n), -1);
                n++;
            end
            @(posedge clk); #1;
        end
        chk("credit_accepts", 64'(n), 8);
        chk("credit_ready_low", 64'(win_ready), 0);
        chk("credit_fifo_valid", 64'(res_valid), 1);
        res_ready = 1'b1;
        chk("credit_ready_same_cycle", 64'(win_ready), 0);
        @(posedge clk); #1;
        chk("credit_ready_returns", 64'(win_ready), 1);
        push_exp(64'(100 + n), -1);
        @(posedge clk); #1;
        win_valid = 1'b0;
        drain("drain_credit");

        // Wraparound across two passes
        cfg = 8'd2;
        push_exp(64'd2, -1);
        send(64'hFFFF_FFFF_FFFF_FFFF, c);
        send(64'd3, c);
        drain("drain_wrap");

        // cfg change mid-result only affects the next result
        cfg = 8'd2;
        push_exp(64'd12, -1);
        push_exp(64'd9, -1);
        push_exp(64'd11, -1);
        send(64'd5, c);
        cfg = 8'd1;
        send(64'd7, c);
        send(64'd9, c);
        send(64'd11, c);
        drain("drain_cfg_change");

        // cfg 0 behaves as a single pass
        cfg = 8'd0;
        push_exp(64'd44, -1);
        send(64'd44, c);
        drain("drain_cfg_zero");

        // Reset with 2 results buffered and 4 windows in flight
        cfg       = 8'd1;
        res_ready = 1'b0;
        send(64'd501, c);
        send(64'd502, c);
        idle(8);
        chk("pre_rst_valid", 64'(res_valid), 1);
        for (int i = 0; i < 4; i++) send(64'(600 + i), c);
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", 64'(res_valid), 0);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_win_ready", 64'(win_ready), 1);
        chk("midrst_res_data", res_data, 0);
        idle(2);
        rst_n     = 1'b1;
        res_ready = 1'b1;
        spurious  = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (res_valid) spurious++;
        end
        chk("no_stale_results", 64'(spurious), 0);
        @(posedge clk); #1;
        push_exp(64'd77, -1);
        send(64'd77, c);
        drain("drain_after_rst");

        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
